// File: rtl/gpio_sponge_io_if.sv
`default_nettype none
// ============================================================================
// Module      : gpio_sponge_io_if
// Description : Lane stream and digest return bundle between the host-side
//               GPIO I/O engine (master) and the Keccak permutation core
//               (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface gpio_sponge_io_if #(
    parameter int LANE_W      = 64,
    parameter int DIGEST_BITS = 512
);
    logic                   lane_valid;
    logic [LANE_W-1:0]      lane_data;
    logic                   lane_ready;
    logic                   block_end;
    logic                   msg_end;
    logic                   digest_valid;
    logic [DIGEST_BITS-1:0] digest;

    // I/O engine side: sources lanes, receives the digest
    modport master (
        output lane_valid, lane_data, block_end, msg_end,
        input  lane_ready, digest_valid, digest
    );

    // Permutation core side
    modport slave (
        input  lane_valid, lane_data, block_end, msg_end,
        output lane_ready, digest_valid, digest
    );
endinterface
`default_nettype wire

// File: rtl/gpio_sponge_io.sv
`default_nettype none
// ============================================================================
// Module      : gpio_sponge_io
// Description : Host-side I/O engine for the Keccak/SHA3 core. Absorbs Pi
//               byte writes into little-endian lanes, applies multi-rate
//               padding, streams lanes to the core and reads the digest back
//               OUT_W bits per GPIO17 edge.
// Options     : KECCAK_LEGACY_PAD_EN - domain pad byte 0x01 instead of 0x06.
// Revision    : 1.0 - initial release
// ============================================================================
module gpio_sponge_io #(
    parameter int LANE_W      = 64,
    parameter int RATE_BYTES  = 72,
    parameter int DIGEST_BITS = 512,
    parameter int OUT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             go,
    input  wire logic             kill,
    input  wire logic             piWR,
    input  wire logic [7:0]       GPIO,
    input  wire logic             dataDone,
    input  wire logic             GPIO17,
    gpio_sponge_io_if.master      bus,
    output logic [OUT_W-1:0]      GPIOout,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic                  led1
);

    localparam int c_BPL    = LANE_W / 8;
    localparam int c_LANES  = RATE_BYTES * 8 / LANE_W;
    localparam int c_WORDS  = DIGEST_BITS / OUT_W;
    localparam int c_BIDX_W = (c_BPL   > 1) ? $clog2(c_BPL)   : 1;
    localparam int c_LIDX_W = (c_LANES > 1) ? $clog2(c_LANES) : 1;
    localparam int c_WIDX_W = (c_WORDS > 1) ? $clog2(c_WORDS) : 1;
    localparam logic [c_BIDX_W-1:0] c_BYTE_LAST = c_BIDX_W'(c_BPL - 1);
    localparam logic [c_LIDX_W-1:0] c_LANE_LAST = c_LIDX_W'(c_LANES - 1);
    localparam logic [c_WIDX_W-1:0] c_WORD_LAST = c_WIDX_W'(c_WORDS - 1);
`ifdef KECCAK_LEGACY_PAD_EN
    localparam logic [7:0] c_PAD_DOMAIN = 8'h01;
`else
    localparam logic [7:0] c_PAD_DOMAIN = 8'h06;
`endif

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_ABSORB      = 3'd1,
        S_PAD         = 3'd2,
        S_WAIT_DIGEST = 3'd3,
        S_SQUEEZE     = 3'd4,
        S_DONE        = 3'd5
    } state_t;

    state_t                 state_q;
    logic [SYNC_STAGES-1:0] wr_sync_q;
    logic [SYNC_STAGES-1:0] g17_sync_q;
    logic                   wr_prev_q;
    logic                   g17_prev_q;
    logic [c_BIDX_W-1:0]    byte_idx_q;
    logic [c_LIDX_W-1:0]    lane_idx_q;
    logic [c_WIDX_W-1:0]    word_idx_q;
    logic [LANE_W-1:0]      acc_q;
    logic                   lane_valid_q;
    logic [LANE_W-1:0]      lane_data_q;
    logic                   block_end_q;
    logic                   msg_end_q;
    logic                   pad_first_q;   // next pad byte carries the domain bits
    logic                   pad_final_q;   // final lane loaded, waiting for acceptance
    logic                   overflow_q;
    logic [DIGEST_BITS-1:0] digest_q;
    logic [OUT_W-1:0]       gpioout_q;

    logic                   w_wr_edge;
    logic                   w_g17_edge;
    logic                   w_byte_last;
    logic                   w_lane_last;
    logic                   w_out_free;
    logic [7:0]             w_pad_byte;
    logic [7:0]             w_in_byte;
    logic [LANE_W-1:0]      w_acc;
    logic [c_BIDX_W-1:0]    w_byte_next;
    logic [c_LIDX_W-1:0]    w_lane_next;
    logic [c_WIDX_W-1:0]    w_word_next;

    // Bring the asynchronous Pi strobes into the clk domain and keep edge history
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_sync_q  <= '0;
            g17_sync_q <= '0;
            wr_prev_q  <= 1'b0;
            g17_prev_q <= 1'b0;
        end else begin
            wr_sync_q  <= {wr_sync_q[SYNC_STAGES-2:0], piWR};
            g17_sync_q <= {g17_sync_q[SYNC_STAGES-2:0], GPIO17};
            wr_prev_q  <= wr_sync_q[SYNC_STAGES-1];
            g17_prev_q <= g17_sync_q[SYNC_STAGES-1];
        end
    end

    assign w_wr_edge  = wr_sync_q[SYNC_STAGES-1] & ~wr_prev_q;
    assign w_g17_edge = g17_sync_q[SYNC_STAGES-1] ^ g17_prev_q;

    // Byte insertion, pad byte generation and counter increments
    always_comb begin
        w_byte_last = (byte_idx_q == c_BYTE_LAST);
        w_lane_last = (lane_idx_q == c_LANE_LAST);
        w_out_free  = !lane_valid_q || bus.lane_ready;
        w_pad_byte  = (pad_first_q ? c_PAD_DOMAIN : 8'h00) |
                      ((w_byte_last && w_lane_last) ? 8'h80 : 8'h00);
        w_in_byte   = (state_q == S_PAD) ? w_pad_byte : GPIO;
        w_acc       = acc_q;
        w_acc[{byte_idx_q, 3'b000} +: 8] = w_in_byte;
        w_byte_next = w_byte_last ? '0 : byte_idx_q + 1'b1;
        w_lane_next = w_lane_last ? '0 : lane_idx_q + 1'b1;
        w_word_next = (word_idx_q == c_WORD_LAST) ? '0 : word_idx_q + 1'b1;
    end

    // Main control FSM with all datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            byte_idx_q   <= '0;
            lane_idx_q   <= '0;
            word_idx_q   <= '0;
            acc_q        <= '0;
            lane_valid_q <= 1'b0;
            lane_data_q  <= '0;
            block_end_q  <= 1'b0;
            msg_end_q    <= 1'b0;
            pad_first_q  <= 1'b0;
            pad_final_q  <= 1'b0;
            overflow_q   <= 1'b0;
            digest_q     <= '0;
            gpioout_q    <= '0;
        end else if (kill) begin
            state_q      <= S_IDLE;
            byte_idx_q   <= '0;
            lane_idx_q   <= '0;
            word_idx_q   <= '0;
            acc_q        <= '0;
            lane_valid_q <= 1'b0;
            lane_data_q  <= '0;
            block_end_q  <= 1'b0;
            msg_end_q    <= 1'b0;
            pad_first_q  <= 1'b0;
            pad_final_q  <= 1'b0;
            overflow_q   <= 1'b0;
            digest_q     <= '0;
            gpioout_q    <= '0;
        end else if (go && (state_q == S_IDLE || state_q == S_SQUEEZE || state_q == S_DONE)) begin
            state_q     <= S_ABSORB;
            byte_idx_q  <= '0;
            lane_idx_q  <= '0;
            overflow_q  <= 1'b0;
            pad_first_q <= 1'b0;
            pad_final_q <= 1'b0;
        end else begin
            if (lane_valid_q && bus.lane_ready) begin
                lane_valid_q <= 1'b0;
            end
            case (state_q)
                S_ABSORB: begin
                    if (w_wr_edge) begin
                        acc_q      <= w_acc;
                        byte_idx_q <= w_byte_next;
                        if (w_byte_last) begin
                            if (w_out_free) begin
                                lane_valid_q <= 1'b1;
                                lane_data_q  <= w_acc;
                                block_end_q  <= w_lane_last;
                                msg_end_q    <= 1'b0;
                                lane_idx_q   <= w_lane_next;
                            end else begin
                                // Output register still full: this lane is lost
                                overflow_q <= 1'b1;
                            end
                        end
                    end
                    if (dataDone) begin
                        state_q     <= S_PAD;
                        pad_first_q <= 1'b1;
                    end
                end
                S_PAD: begin
                    if (pad_final_q) begin
                        if (lane_valid_q && bus.lane_ready) begin
                            state_q     <= S_WAIT_DIGEST;
                            pad_final_q <= 1'b0;
                        end
                    end else if (w_out_free) begin
                        // Advance only when a completing lane has somewhere to go
                        acc_q       <= w_acc;
                        byte_idx_q  <= w_byte_next;
                        pad_first_q <= 1'b0;
                        if (w_byte_last) begin
                            lane_valid_q <= 1'b1;
                            lane_data_q  <= w_acc;
                            block_end_q  <= w_lane_last;
                            msg_end_q    <= w_lane_last;
                            lane_idx_q   <= w_lane_next;
                            pad_final_q  <= w_lane_last;
                        end
                    end
                end
                S_WAIT_DIGEST: begin
                    if (bus.digest_valid) begin
                        digest_q   <= bus.digest;
                        word_idx_q <= '0;
                        gpioout_q  <= bus.digest[OUT_W-1:0];
                        state_q    <= S_SQUEEZE;
                    end
                end
                S_SQUEEZE: begin
                    if (w_g17_edge) begin
                        word_idx_q <= w_word_next;
                        gpioout_q  <= digest_q[int'(w_word_next) * OUT_W +: OUT_W];
                        if (word_idx_q == c_WORD_LAST) begin
                            state_q <= S_DONE;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.lane_valid = lane_valid_q;
    assign bus.lane_data  = lane_data_q;
    assign bus.block_end  = block_end_q;
    assign bus.msg_end    = msg_end_q;
    assign GPIOout        = gpioout_q;
    assign overflow       = overflow_q;
    assign busy           = !(state_q == S_IDLE || state_q == S_DONE);
    assign done           = (state_q == S_SQUEEZE) || (state_q == S_DONE);
    assign led1           = done;

endmodule
`default_nettype wire

// File: tb/tb_gpio_sponge_io.sv
`default_nettype none
// ============================================================================
// Module      : tb_gpio_sponge_io
// Description : Directed self-checking bench for gpio_sponge_io (SHA3-512
//               default configuration).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gpio_sponge_io;

    logic        clk      = 1'b0;
    logic        reset    = 1'b0;
    logic        go       = 1'b0;
    logic        kill     = 1'b0;
    logic        piWR     = 1'b0;
    logic [7:0]  GPIO     = 8'h00;
    logic        dataDone = 1'b0;
    logic        GPIO17   = 1'b0;
    logic [15:0] GPIOout;
    logic        busy;
    logic        done;
    logic        overflow;
    logic        led1;

    int          n_vec = 0;
    int          n_err = 0;
    logic [65:0] lanes_q[$];
    logic [511:0] dig;
    logic [63:0] held;

    always #5 clk = ~clk;

    gpio_sponge_io_if #(.LANE_W(64), .DIGEST_BITS(512)) bus ();

    gpio_sponge_io #(
        .LANE_W(64), .RATE_BYTES(72), .DIGEST_BITS(512), .OUT_W(16), .SYNC_STAGES(2)
    ) dut (
        .clk(clk), .reset(reset), .go(go), .kill(kill), .piWR(piWR), .GPIO(GPIO),
        .dataDone(dataDone), .GPIO17(GPIO17), .bus(bus.master), .GPIOout(GPIOout),
        .busy(busy), .done(done), .overflow(overflow), .led1(led1)
    );

    // Record every accepted lane as {msg_end, block_end, data}
    always @(negedge clk) begin
        if (reset && bus.lane_valid && bus.lane_ready)
            lanes_q.push_back({bus.msg_end, bus.block_end, bus.lane_data});
    end

    task automatic chk_vec(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [65:0] ln(input logic m, input logic b, input logic [63:0] d);
        return {m, b, d};
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wr_byte(input logic [7:0] b);
        GPIO = b;
        piWR = 1'b1;
        tick(4);
        piWR = 1'b0;
        tick(3);
    endtask

    task automatic toggle17(input int n);
        repeat (n) begin
            GPIO17 = ~GPIO17;
            tick(5);
        end
    endtask

    task automatic wait_lanes(input int n, input string tag);
        int cyc = 0;
        while (lanes_q.size() < n && cyc < 3000) begin
            tick(1);
            cyc++;
        end
        chk_vec(tag, lanes_q.size(), n);
    endtask

    function automatic logic [65:0] lane_at(input int i);
        return (i < lanes_q.size()) ? lanes_q[i] : 66'h3_dead_dead_dead_dead;
    endfunction

    // A full padding-only block starting at lane index base
    task automatic check_empty(input int base, input string tag);
        logic [65:0] exp;
        for (int i = 0; i < 9; i++) begin
            if (i == 0)      exp = ln(1'b0, 1'b0, 64'h0000_0000_0000_0006);
            else if (i == 8) exp = ln(1'b1, 1'b1, 64'h8000_0000_0000_0000);
            else             exp = '0;
            chk_vec($sformatf("%s_lane%0d", tag, i), lane_at(base + i), exp);
        end
    endtask

    task automatic start_msg();
        go = 1'b1;
        tick(1);
        go = 1'b0;
        lanes_q.delete();
    endtask

    task automatic end_msg();
        dataDone = 1'b1;
        tick(1);
        dataDone = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.lane_ready   = 1'b1;
        bus.digest_valid = 1'b0;
        bus.digest       = '0;
        tick(3);
        chk_vec("reset_flags", {busy, done, overflow, bus.lane_valid, led1}, 5'b0);
        chk_vec("reset_gpioout", GPIOout, 16'h0000);
        reset = 1'b1;
        tick(2);

        // Empty message
        start_msg();
        chk_vec("absorb_busy", {busy, done}, 2'b10);
        end_msg();
        wait_lanes(9, "empty_count");
        check_empty(0, "empty");
        tick(2);
        chk_vec("wait_digest_flags", {busy, done}, 2'b10);

        // Digest readback
        for (int i = 0; i < 32; i++) dig[i*16 +: 16] = 16'h1000 + 16'(i);
        dig[15:0]    = 16'h1234;
        dig[31:16]   = 16'h5678;
        dig[511:496] = 16'hBEEF;
        bus.digest = dig;
        bus.digest_valid = 1'b1;
        tick(1);
        bus.digest_valid = 1'b0;
        bus.digest = '0;
        chk_vec("sq_word0", GPIOout, 16'h1234);
        chk_vec("sq_flags", {busy, done, led1}, 3'b111);
        toggle17(1);
        chk_vec("sq_word1", GPIOout, 16'h5678);
        toggle17(29);
        chk_vec("sq_word30", GPIOout, 16'h101E);
        toggle17(1);
        chk_vec("sq_word31", GPIOout, 16'hBEEF);
        toggle17(1);
        chk_vec("sq_wrap", GPIOout, 16'h1234);
        chk_vec("done_flags", {busy, done, led1}, 3'b011);
        toggle17(1);
        chk_vec("done_hold", GPIOout, 16'h1234);
        bus.digest = {32{16'hAAAA}};
        bus.digest_valid = 1'b1;
        tick(1);
        bus.digest_valid = 1'b0;
        tick(1);
        chk_vec("digest_ignored", GPIOout, 16'h1234);

        // 71 bytes: pad bytes share the final byte
        start_msg();
        repeat (71) wr_byte(8'hFF);
        end_msg();
        wait_lanes(9, "b71_count");
        chk_vec("b71_lane0", lane_at(0), ln(1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF));
        chk_vec("b71_lane7", lane_at(7), ln(1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF));
        chk_vec("b71_lane8", lane_at(8), ln(1'b1, 1'b1, 64'h86FF_FFFF_FFFF_FFFF));
        tick(2);

        // 72 bytes: full extra padding block
        kill = 1'b1;
        tick(1);
        kill = 1'b0;
        start_msg();
        repeat (72) wr_byte(8'hAB);
        end_msg();
        wait_lanes(18, "b72_count");
        chk_vec("b72_lane7", lane_at(7), ln(1'b0, 1'b0, {8{8'hAB}}));
        chk_vec("b72_lane8", lane_at(8), ln(1'b0, 1'b1, {8{8'hAB}}));
        check_empty(9, "b72_pad");
        tick(2);

        // Backpressure overflow
        kill = 1'b1;
        tick(1);
        kill = 1'b0;
        start_msg();
        bus.lane_ready = 1'b0;
        for (int i = 0; i < 16; i++) wr_byte(8'(i));
        tick(2);
        chk_vec("ovf_valid", bus.lane_valid, 1'b1);
        chk_vec("ovf_held", bus.lane_data, 64'h0706_0504_0302_0100);
        chk_vec("ovf_flag", overflow, 1'b1);
        held = bus.lane_data;
        tick(5);
        chk_vec("ovf_stable", bus.lane_data, held);
        bus.lane_ready = 1'b1;
        end_msg();
        wait_lanes(9, "ovf_count");
        chk_vec("ovf_lane0", lane_at(0), ln(1'b0, 1'b0, 64'h0706_0504_0302_0100));
        chk_vec("ovf_lane1", lane_at(1), ln(1'b0, 1'b0, 64'h0000_0000_0000_0006));
        chk_vec("ovf_lane8", lane_at(8), ln(1'b1, 1'b1, 64'h8000_0000_0000_0000));
        tick(2);
        bus.digest = dig;
        bus.digest_valid = 1'b1;
        tick(1);
        bus.digest_valid = 1'b0;
        toggle17(32);
        chk_vec("ovf_sticky", {overflow, done, busy}, 3'b110);
        start_msg();
        chk_vec("go_clears_ovf", {overflow, busy}, 2'b01);

        // Kill mid-message, then an empty message must match the first run
        for (int i = 0; i < 20; i++) wr_byte(8'h40 + 8'(i));
        kill = 1'b1;
        tick(1);
        kill = 1'b0;
        chk_vec("kill_flags", {busy, done, bus.lane_valid, overflow}, 4'b0);
        chk_vec("kill_gpioout", GPIOout, 16'h0000);
        start_msg();
        end_msg();
        wait_lanes(9, "rerun_count");
        check_empty(0, "rerun");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
